// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with parallel load, terminal-count flag and sticky overflow.
// Define PARAM_UPDOWN_COUNTER_SAT_EN to saturate at the end points instead of wrapping.
module param_updown_counter #(
    parameter int unsigned          WIDTH   = 4,
    parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tc_s;

    // Terminal count: an enabled step that would cross an end point; rst deliberately not involved.
    always_comb begin
        tc_s = 1'b0;
        if (en && !load) begin
            if (up_dn) begin
                tc_s = (count_q == MAX_VAL);
            end else begin
                tc_s = (count_q == ZERO);
            end
        end else begin
            tc_s = 1'b0;
        end
    end

    // Next count: load (clamped) beats enable, which beats hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            if (load_val > MAX_VAL) begin
                count_d = MAX_VAL;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (tc_s) begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
                count_d = count_q;
`else
                count_d = up_dn ? ZERO : MAX_VAL;
`endif
            end else if (up_dn) begin
                count_d = count_q + ONE;
            end else begin
                count_d = count_q - ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Sticky overflow: a wrap/saturation on this edge overrides a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (tc_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= ZERO;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = tc_s;

endmodule
